// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - shared types and constants for the serial pattern generator
// Contents: state_t encoding (IDLE, SHIFT, GAP, DONE), DEF_PAT_1010 default pattern,
// frame_len() helper giving bits per frame (pattern width, plus one parity bit when
// SEQ_GEN_PARITY_EN is defined).
package seq_gen_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t GAP   = 2'd2;
    localparam state_t DONE  = 2'd3;

    localparam logic [3:0] DEF_PAT_1010 = 4'b1010;

`ifdef SEQ_GEN_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_len(input int pat_w);
        return pat_w + PARITY_BITS;
    endfunction

endpackage

// File: rtl/seq_shreg.sv
// rtl/seq_shreg.sv - load/shift-left frame register with bit counter
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   load          load load_val and restart the bit counter (wins over shift)
//   shift         shift left by one with zero fill, advance the bit counter
//   load_val[W]   frame word, MSB transmitted first
//   msb           current MSB of the register (the serial bit)
//   last_bit      the bit on msb is the final bit of the frame
module seq_shreg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_val,
    output logic         msb,
    output logic         last_bit
);

    localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    logic [W-1:0]     data;
    logic [CNT_W-1:0] cnt;

    // Shifting out the last bit zero-fills the whole register, so msb reads 0
    // during gaps, DONE and IDLE without any extra clearing logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
            cnt  <= '0;
        end else if (load) begin
            data <= load_val;
            cnt  <= '0;
        end else if (shift) begin
            data <= {data[W-2:0], 1'b0};
            cnt  <= last_bit ? '0 : cnt + 1'b1;
        end
    end

    assign msb      = data[W-1];
    assign last_bit = (cnt == CNT_LAST);

endmodule

// File: rtl/seq_1010_gen.sv
// rtl/seq_1010_gen.sv - serial pattern transmitter, (rep+1) frames MSB-first with zero gaps
// Optional macro: SEQ_GEN_PARITY_EN appends an even-parity bit to every frame.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   start          request, accepted only while ready=1
//   use_def        1 = send DEF_PAT, 0 = send pat_in (sampled with start)
//   pat_in[PAT_W]  user pattern (sampled with start)
//   rep[REP_W]     number of frames minus one (sampled with start)
//   o              serial data bit
//   valid          o carries a frame bit
//   ready          idle, start accepted
//   busy           ~ready
//   done           one-cycle pulse after the last bit of the last frame
module seq_1010_gen
    import seq_gen_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter int               REP_W   = 4,
    parameter int               GAP_CYC = 2,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_1010)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             use_def,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [REP_W-1:0] rep,
    output logic             o,
    output logic             valid,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    localparam int FRAME_W = frame_len(PAT_W);
    localparam int GAP_W   = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    state_t             state, state_nxt;
    logic [FRAME_W-1:0] frame_q;
    logic [FRAME_W-1:0] word_in;
    logic [FRAME_W-1:0] load_val;
    logic [PAT_W-1:0]   pat_sel;
    logic [REP_W-1:0]   rep_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               sh_load, sh_shift, last_bit, frame_end;

    assign pat_sel = use_def ? DEF_PAT : pat_in;

`ifdef SEQ_GEN_PARITY_EN
    assign word_in = {pat_sel, ^pat_sel};
`else
    assign word_in = pat_sel;
`endif

    // First frame loads straight from the inputs; later frames reload the latched copy.
    assign load_val  = (state == IDLE) ? word_in : frame_q;
    assign frame_end = (state == SHIFT) && last_bit;

    always_comb begin
        state_nxt = state;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    sh_load   = 1'b1;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    sh_shift = 1'b1;
                end else if (rep_cnt == '0) begin
                    state_nxt = DONE;
                    sh_shift  = 1'b1;
                end else if (GAP_CYC == 0) begin
                    sh_load = 1'b1;
                end else begin
                    state_nxt = GAP;
                    sh_shift  = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = SHIFT;
                    sh_load   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            frame_q <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            valid   <= 1'b0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                frame_q <= word_in;
                rep_cnt <= rep;
            end else if (frame_end && rep_cnt != '0) begin
                rep_cnt <= rep_cnt - 1'b1;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            // Status outputs come from the next state so they line up with the
            // registered serial bit in the same cycle.
            valid <= (state_nxt == SHIFT);
            ready <= (state_nxt == IDLE);
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
        end
    end

    seq_shreg #(
        .W (FRAME_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .shift    (sh_shift),
        .load_val (load_val),
        .msb      (o),
        .last_bit (last_bit)
    );

endmodule
